// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the interpolation RAM: round-robin ownership
// with req/gnt handshake, bounded bursts, and registered read return.
module ram_port_arbiter #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned MAX_BURST     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     rd0,
    input  logic                     rd1,
    input  logic                     wr0,
    input  logic                     wr1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [WORD_SIZE-1:0]     wdata0,
    input  logic [WORD_SIZE-1:0]     wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic [WORD_SIZE-1:0]     rdata,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic                     err,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [WORD_SIZE-1:0]     ram_wr_data,
    input  logic [WORD_SIZE-1:0]     ram_rd_data
);

    localparam int unsigned CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             last_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rd_ok0;
    logic             rd_ok1;
    logic             bad_strobe;

    // Grants are a direct decode of the state register.
    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    // Only the current owner's strobes reach the RAM or the read pipe.
    assign rd_ok0     = gnt0 & rd0;
    assign rd_ok1     = gnt1 & rd1;
    assign bad_strobe = ((rd0 | wr0) & ~gnt0) | ((rd1 | wr1) & ~gnt1);

    // State, burst counter and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: arbitration, release handoff and burst preemption.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = cnt;
        last_nxt  = last;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_nxt = req1 ? OWN1 : IDLE;
                end else begin
                    if ((rd0 || wr0) && (cnt < CNT_MAX)) begin
                        cnt_inc = cnt + CNT_W'(1);
                    end
                    if ((cnt_inc == CNT_MAX) && req1) begin
                        state_nxt = OWN1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_nxt = req0 ? OWN0 : IDLE;
                end else begin
                    if ((rd1 || wr1) && (cnt < CNT_MAX)) begin
                        cnt_inc = cnt + CNT_W'(1);
                    end
                    if ((cnt_inc == CNT_MAX) && req0) begin
                        state_nxt = OWN0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A new owner always starts a fresh burst.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end

        if (state_nxt == OWN0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == OWN1) begin
            last_nxt = 1'b1;
        end
    end

    // RAM port mux driven by the current owner; idle drives zeros.
    always_comb begin
        ram_we      = 1'b0;
        ram_rd_addr = '0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        case (state)
            OWN0: begin
                ram_we      = wr0;
                ram_rd_addr = addr0;
                ram_wr_addr = addr0;
                ram_wr_data = wdata0;
            end
            OWN1: begin
                ram_we      = wr1;
                ram_rd_addr = addr1;
                ram_wr_addr = addr1;
                ram_wr_data = wdata1;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Read return pipe and sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid0 <= rd_ok0;
            rvalid1 <= rd_ok1;
            if (rd_ok0 || rd_ok1) begin
                rdata <= ram_rd_data;
            end
            if (bad_strobe) begin
                err <= 1'b1;
            end
        end
    end

endmodule
